// File: rtl/bp_pkg.sv
// Shared helpers for the branch predictor: counter reset value, saturating step, index hash.
// Pure combinational functions, no state.
// No flow control; callers size results with a width cast.
package bp_pkg;

   // Largest value representable in w bits (w capped at 32).
   function automatic logic [31:0] sat_max(input int unsigned w);
      logic [31:0] mx;
      if (w >= 32) begin
         mx = '1;
      end else begin
         mx = (32'd1 << w) - 32'd1;
      end
      return mx;
   endfunction

   // Weakly not-taken: one below the midpoint of a w-bit counter.
   function automatic int unsigned ctr_init(input int unsigned w);
      return (32'd1 << (w - 1)) - 32'd1;
   endfunction

   // One saturating step of a w-bit counter: up increments and holds at the max,
   // down decrements and holds at zero.
   function automatic logic [31:0] sat_step(input logic [31:0] v,
                                            input logic        up,
                                            input int unsigned w);
      logic [31:0] mx;
      logic [31:0] nv;
      mx = sat_max(w);
      if (up) begin
         nv = (v >= mx) ? mx : v + 32'd1;
      end else begin
         nv = (v == 32'd0) ? 32'd0 : v - 32'd1;
      end
      return nv;
   endfunction

   // Table index: PC word-address bits XOR history, masked to idx_w bits.
   // With history tied to zero this is plain PC indexing.
   function automatic logic [31:0] idx_hash(input logic [63:0]  pc,
                                            input logic [31:0]  hist,
                                            input int unsigned  idx_w);
      logic [63:0] word_addr;
      word_addr = pc >> 2;
      return (word_addr[31:0] ^ hist) & sat_max(idx_w);
   endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// One CTR_W-bit saturating direction counter; exposes only its MSB as the taken hint.
// Update takes effect at the clock edge where en_i is sampled; value visible next cycle.
// No flow control; an enabled update is always accepted.
module bp_sat_ctr
   import bp_pkg::*;
#(
   parameter int unsigned CTR_W = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic up_i,
   output logic taken_o
);

   localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(ctr_init(CTR_W));

   logic [CTR_W-1:0] ctr_q;
   logic [CTR_W-1:0] ctr_d;

   // Next value: one saturating step in the resolved direction when enabled.
   always_comb begin
      ctr_d = ctr_q;
      if (en_i) begin
         ctr_d = CTR_W'(sat_step(32'(ctr_q), up_i, CTR_W));
      end
   end

   // Counter register, reloaded to the weakly not-taken value on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctr_q <= CTR_RST;
      end else begin
         ctr_q <= ctr_d;
      end
   end

   assign taken_o = ctr_q[CTR_W-1];

endmodule

// File: rtl/bp_table.sv
// Branch direction predictor: 2^IDX_W saturating counters, optional gshare hash (GSHARE_EN).
// Prediction registered one cycle after the request; training visible to the next request.
// No backpressure: a request and an update may each be accepted every cycle.
module bp_table
   import bp_pkg::*;
#(
   parameter int unsigned IDX_W = 4,
   parameter int unsigned CTR_W = 2,
   parameter int unsigned PC_W  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic [PC_W-1:0]  req_pc,
   output logic             pred_valid,
   output logic             pred_taken,
   output logic [IDX_W-1:0] pred_idx,
   input  logic             upd_valid,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken,
   input  logic             upd_pred,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam int unsigned DEPTH = 1 << IDX_W;

   logic [DEPTH-1:0] ctr_msb;
   logic [IDX_W-1:0] hist;
   logic [IDX_W-1:0] req_idx;

   logic             pred_valid_q, pred_valid_d;
   logic             pred_taken_q, pred_taken_d;
   logic [IDX_W-1:0] pred_idx_q,   pred_idx_d;
   logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

`ifdef GSHARE_EN
   logic [IDX_W-1:0] ghr_q, ghr_d;

   // History shifts in every resolved outcome, oldest bit falls off the top.
   always_comb begin
      ghr_d = ghr_q;
      if (upd_valid) begin
         ghr_d = {ghr_q[IDX_W-2:0], upd_taken};
      end
   end

   // History register; requests hash with the value held at their sampling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         ghr_q <= '0;
      end else begin
         ghr_q <= ghr_d;
      end
   end

   assign hist = ghr_q;
`else
   assign hist = '0;
`endif

   // Counter array; only the entry addressed by upd_idx steps on an update.
   for (genvar i = 0; i < DEPTH; i++) begin : g_ctr
      bp_sat_ctr #(
         .CTR_W   (CTR_W)
      ) u_ctr (
         .clk     (clk),
         .rst     (rst),
         .en_i    (upd_valid && (upd_idx == IDX_W'(i))),
         .up_i    (upd_taken),
         .taken_o (ctr_msb[i])
      );
   end

   // Request index and lookup; reads the registered counters, so a same-cycle
   // update to the same entry is not seen (read-before-write).
   always_comb begin
      req_idx      = IDX_W'(idx_hash(64'(req_pc), 32'(hist), IDX_W));
      pred_valid_d = req_valid;
      pred_taken_d = pred_taken_q;
      pred_idx_d   = pred_idx_q;
      if (req_valid) begin
         pred_taken_d = ctr_msb[req_idx];
         pred_idx_d   = req_idx;
      end
   end

   // Mispredict counter steps on each update whose prediction was wrong, holding at max.
   always_comb begin
      mispred_cnt_d = mispred_cnt_q;
      if (upd_valid && (upd_pred != upd_taken)) begin
         mispred_cnt_d = CNT_W'(sat_step(32'(mispred_cnt_q), 1'b1, CNT_W));
      end
   end

   // Output and monitor registers; reset drops any in-flight prediction.
   always_ff @(posedge clk) begin
      if (rst) begin
         pred_valid_q  <= 1'b0;
         pred_taken_q  <= 1'b0;
         pred_idx_q    <= '0;
         mispred_cnt_q <= '0;
      end else begin
         pred_valid_q  <= pred_valid_d;
         pred_taken_q  <= pred_taken_d;
         pred_idx_q    <= pred_idx_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign pred_valid  = pred_valid_q;
   assign pred_taken  = pred_taken_q;
   assign pred_idx    = pred_idx_q;
   assign mispred_cnt = mispred_cnt_q;

endmodule
